// File: rtl/calc_result_display.sv
// Result display stage: converts a 7-bit calculator result to 3 BCD digits with a
// sequential double-dabble engine and scans them onto a multiplexed 7-segment display.
module calc_result_display #(
    parameter int unsigned REFRESH_DIV = 16,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] value,
    output logic       busy,
    output logic       valid,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [6:0] seg,
    output logic [2:0] an
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_OFF      = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]  AN_OFF       = ACTIVE_LOW ? 3'b111 : 3'b000;

    state_e      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [6:0]  shift_q, shift_d;
    logic [11:0] scratch_q, scratch_d;
    logic        pend_q, pend_d;
    logic [6:0]  pend_val_q, pend_val_d;
    logic        valid_q, valid_d;
    logic [11:0] bcd_q, bcd_d;
    logic [15:0] refresh_q, refresh_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [2:0]  an_q, an_d;

    logic [11:0] adj;
    logic [3:0]  digit;
    logic        digit_en;
    logic [2:0]  an_onehot;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Conversion engine: one add-3/shift iteration per clock, commit on the seventh.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        valid_d    = valid_q;
        bcd_d      = bcd_q;
        adj        = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d   = value;
                    scratch_d = '0;
                    count_d   = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[10:0], shift_q[6]};
                shift_d   = {shift_q[5:0], 1'b0};
                count_d   = count_q + 3'd1;
                if (count_q == 3'd6) begin
                    bcd_d   = {adj[10:0], shift_q[6]};
                    valid_d = 1'b1;
                    // A fresh load at the commit edge takes precedence over the held one.
                    if (load) begin
                        shift_d   = value;
                        scratch_d = '0;
                        count_d   = '0;
                    end else if (pend_q) begin
                        shift_d   = pend_val_q;
                        scratch_d = '0;
                        count_d   = '0;
                        pend_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (load) begin
                    pend_d     = 1'b1;
                    pend_val_d = value;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Display scan: registered outputs follow the index and committed digits by one clock.
    always_comb begin
        refresh_d = (refresh_q == REFRESH_LAST) ? 16'd0 : refresh_q + 16'd1;
        idx_d     = idx_q;
        if (refresh_q == REFRESH_LAST) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        an_onehot = 3'b001 << idx_q;
        case (idx_q)
            2'd0: begin
                digit    = bcd_q[3:0];
                digit_en = valid_q;
            end
            2'd1: begin
                digit    = bcd_q[7:4];
                digit_en = valid_q && (bcd_q[11:8] != 4'd0 || bcd_q[7:4] != 4'd0);
            end
            2'd2: begin
                digit    = bcd_q[11:8];
                digit_en = valid_q && (bcd_q[11:8] != 4'd0);
            end
            default: begin
                digit    = 4'd0;
                digit_en = 1'b0;
            end
        endcase

        if (digit_en) begin
            seg_d = ACTIVE_LOW ? ~seg_code(digit) : seg_code(digit);
            an_d  = ACTIVE_LOW ? ~an_onehot : an_onehot;
        end else begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shift_q    <= '0;
            scratch_q  <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            valid_q    <= 1'b0;
            bcd_q      <= '0;
            refresh_q  <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_OFF;
            an_q       <= AN_OFF;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            valid_q    <= valid_d;
            bcd_q      <= bcd_d;
            refresh_q  <= refresh_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign busy         = (state_q == SHIFT);
    assign valid        = valid_q;
    assign bcd_hundreds = bcd_q[11:8];
    assign bcd_tens     = bcd_q[7:4];
    assign bcd_ones     = bcd_q[3:0];
    assign seg          = seg_q;
    assign an           = an_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display with REFRESH_DIV=4 and active-low display drive.
module tb_calc_result_display;

    localparam int unsigned REFRESH_DIV = 4;

    logic       clk;
    logic       reset;
    logic       load;
    logic [6:0] value;
    logic       busy;
    logic       valid;
    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] seg;
    logic [2:0] an;

    int n_cmp = 0;
    int n_bad = 0;

    // Active-low gfedcba patterns for digits 0..9.
    logic [6:0] seg_lo [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    calc_result_display #(
        .REFRESH_DIV(REFRESH_DIV),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .busy        (busy),
        .valid       (valid),
        .bcd_hundreds(bcd_hundreds),
        .bcd_tens    (bcd_tens),
        .bcd_ones    (bcd_ones),
        .seg         (seg),
        .an          (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] bcd_now();
        return {bcd_hundreds, bcd_tens, bcd_ones};
    endfunction

    // Assert load for one edge (E0) and leave the bench just after that edge.
    task automatic start_load(input logic [6:0] v);
        load  = 1'b1;
        value = v;
        tick();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load  = 1'b0;
        value = '0;
        repeat (3) tick();
        reset = 1'b1;
        n_cmp++;
        if (bcd_now() !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_bcd: got %h want 000", bcd_now());
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            n_cmp++;
            if ({busy, valid, seg, an} !== {1'b0, 1'b0, 7'h7F, 3'b111}) begin
                n_bad++;
                $display("FAIL idle_outputs cyc %0d: busy=%b valid=%b seg=%b an=%b want 0 0 1111111 111",
                         i, busy, valid, seg, an);
            end
        end
    endtask

    // Plain conversion: busy for E0..E6 with old digits held, commit visible after E7.
    task automatic test_convert(input logic [6:0] v, input logic [11:0] prev, input logic [11:0] exp);
        start_load(v);
        for (int e = 1; e <= 7; e++) begin
            n_cmp++;
            if (busy !== 1'b1 || bcd_now() !== prev) begin
                n_bad++;
                $display("FAIL conv_%0d_busy E%0d: busy=%b bcd=%h want busy=1 bcd=%h", v, e - 1, busy, bcd_now(), prev);
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || valid !== 1'b1 || bcd_now() !== exp) begin
            n_bad++;
            $display("FAIL conv_%0d_commit: busy=%b valid=%b bcd=%h want 0 1 %h", v, busy, valid, bcd_now(), exp);
        end
    endtask

    // Scan the display and check every (an, seg) pair against the committed digits.
    task automatic test_display(input logic [11:0] digits, input bit check_period);
        logic [3:0] h, t, o;
        logic       en_t, en_h, ok;
        logic [6:0] exp_seg;
        logic [2:0] prev_an;
        int         seen0, seen1, seen2, run, changes;
        h = digits[11:8];
        t = digits[7:4];
        o = digits[3:0];
        en_t = (h != 0) || (t != 0);
        en_h = (h != 0);
        seen0 = 0; seen1 = 0; seen2 = 0; run = 0; changes = 0;
        tick();
        prev_an = an;
        for (int i = 0; i < 24; i++) begin
            tick();
            ok = 1'b1;
            exp_seg = 7'h7F;
            case (an)
                3'b110: begin exp_seg = seg_lo[o]; seen0++; end
                3'b101: begin exp_seg = seg_lo[t]; ok = en_t; seen1++; end
                3'b011: begin exp_seg = seg_lo[h]; ok = en_h; seen2++; end
                3'b111: ok = !(en_t && en_h);
                default: ok = 1'b0;
            endcase
            n_cmp++;
            if (!ok || seg !== exp_seg) begin
                n_bad++;
                $display("FAIL disp_%h cyc %0d: an=%b seg=%b want seg=%b legal=%b", digits, i, an, seg, exp_seg, ok);
            end
            if (an !== prev_an) begin
                if (check_period && changes > 0) begin
                    n_cmp++;
                    if (run != REFRESH_DIV) begin
                        n_bad++;
                        $display("FAIL disp_%h_period: digit lit %0d cycles want %0d", digits, run, REFRESH_DIV);
                    end
                end
                changes++;
                run = 1;
            end else begin
                run++;
            end
            prev_an = an;
        end
        n_cmp++;
        if (seen0 == 0 || (seen1 > 0) != en_t || (seen2 > 0) != en_h) begin
            n_bad++;
            $display("FAIL disp_%h_coverage: ones=%0d tens=%0d hundreds=%0d want tens_en=%b hund_en=%b",
                     digits, seen0, seen1, seen2, en_t, en_h);
        end
    endtask

    // 5 loads; 99 arrives at E2, 42 at E4; only 5 and 42 may ever commit.
    task automatic test_back_to_back(input logic [11:0] prev);
        start_load(7'd5);
        for (int e = 1; e <= 14; e++) begin
            load  = (e == 2) || (e == 4);
            value = (e == 2) ? 7'd99 : 7'd42;
            tick();
            load = 1'b0;
            n_cmp++;
            if (bcd_now() === 12'h099) begin
                n_bad++;
                $display("FAIL b2b_dropped E%0d: bcd=%h must never be 099", e, bcd_now());
            end
            if (e == 7) begin
                n_cmp++;
                if (bcd_now() !== 12'h005 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_first_commit: bcd=%h busy=%b want 005 1", bcd_now(), busy);
                end
            end else if (e == 14) begin
                n_cmp++;
                if (bcd_now() !== 12'h042 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_pending_commit: bcd=%h busy=%b want 042 0", bcd_now(), busy);
                end
            end else begin
                n_cmp++;
                if (busy !== 1'b1 || bcd_now() !== ((e < 7) ? prev : 12'h005)) begin
                    n_bad++;
                    $display("FAIL b2b_hold E%0d: busy=%b bcd=%h", e, busy, bcd_now());
                end
            end
        end
    endtask

    // 64 converts; 13 is loaded exactly at the commit edge and follows without a gap.
    task automatic test_load_at_commit(input logic [11:0] prev);
        start_load(7'd64);
        for (int e = 1; e <= 14; e++) begin
            load  = (e == 7);
            value = 7'd13;
            tick();
            load = 1'b0;
            if (e == 7) begin
                n_cmp++;
                if (bcd_now() !== 12'h064 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL commit_load_first: bcd=%h busy=%b want 064 1", bcd_now(), busy);
                end
            end else if (e == 14) begin
                n_cmp++;
                if (bcd_now() !== 12'h013 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL commit_load_second: bcd=%h busy=%b want 013 0", bcd_now(), busy);
                end
            end else begin
                n_cmp++;
                if (busy !== 1'b1 || bcd_now() !== ((e < 7) ? prev : 12'h064)) begin
                    n_bad++;
                    $display("FAIL commit_load_hold E%0d: busy=%b bcd=%h", e, busy, bcd_now());
                end
            end
        end
    endtask

    // Reset lands at E3 of converting 100; nothing may commit, then 9 converts normally.
    task automatic test_reset_mid(input logic [11:0] prev);
        start_load(7'd100);
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({busy, valid, bcd_now(), seg, an} !== {1'b0, 1'b0, 12'h000, 7'h7F, 3'b111}) begin
            n_bad++;
            $display("FAIL mid_reset: busy=%b valid=%b bcd=%h seg=%b an=%b want 0 0 000 1111111 111",
                     busy, valid, bcd_now(), seg, an);
        end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0 || valid !== 1'b0 || bcd_now() !== 12'h000) begin
                n_bad++;
                $display("FAIL mid_reset_discard cyc %0d: busy=%b valid=%b bcd=%h want 0 0 000",
                         i, busy, valid, bcd_now());
            end
        end
        test_convert(7'd9, 12'h000, 12'h009);
        test_display(12'h009, 1'b0);
        n_cmp++;
        if (prev === 12'h100 && bcd_now() === 12'h100) begin
            n_bad++;
            $display("FAIL mid_reset_never_100: bcd=%h", bcd_now());
        end
    endtask

    initial begin
        reset = 1'b0;
        load  = 1'b0;
        value = '0;
        test_reset();
        test_convert(7'd127, 12'h000, 12'h127);
        test_display(12'h127, 1'b1);
        test_convert(7'd0, 12'h127, 12'h000);
        test_display(12'h000, 1'b0);
        test_back_to_back(12'h000);
        test_load_at_commit(12'h042);
        test_reset_mid(12'h013);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
